// File: rtl/summation_m_pkg.sv
// Shared constants and types for the modulo-M signed accumulator.
// Consumers of cnt can use cnt_t to match the default accumulator width.
package summation_m_pkg;

  localparam int SUM_W_DEF = 11;
  localparam int SUM_M_DEF = 1000;

  typedef logic signed [SUM_W_DEF-1:0] cnt_t;

  // Direction of the single modulus correction applied to a sum.
  typedef enum logic [1:0] {
    WRAP_NONE = 2'd0,
    WRAP_POS  = 2'd1,
    WRAP_NEG  = 2'd2
  } wrap_e;

endpackage

// File: rtl/summation_m_mod_wrap.sv
// Combinational modulo-M correction of a sign-extended sum.
// At most one +/-M correction is applied; s is expected in [-(M-1), 2M-2].
module mod_wrap
  import summation_m_pkg::*;
#(
  parameter int W = SUM_W_DEF,
  parameter int M = SUM_M_DEF
) (
  input  logic signed [W:0]   s,
  output logic signed [W-1:0] wrapped,
  output logic                carry,
  output logic                borrow
);

  localparam logic signed [W:0] M_S = (W+1)'(M);
  localparam logic [W-1:0]      M_W = W'(M);

  wrap_e dir;

  always_comb begin
    dir = WRAP_NONE;
    if (s >= M_S) begin
      dir = WRAP_POS;
    end else if (s[W]) begin
      dir = WRAP_NEG;
    end
  end

  // The corrected value always fits in W bits, so the low bits suffice.
  always_comb begin
    wrapped = s[W-1:0];
    carry   = 1'b0;
    borrow  = 1'b0;
    unique case (dir)
      WRAP_POS: begin
        wrapped = s[W-1:0] - M_W;
        carry   = 1'b1;
      end
      WRAP_NEG: begin
        wrapped = s[W-1:0] + M_W;
        borrow  = 1'b1;
      end
      default: begin
        wrapped = s[W-1:0];
      end
    endcase
  end

endmodule

// File: rtl/summation_m.sv
// Modulo-M signed accumulator: register stage around mod_wrap.
// cnt stays in 0..M-1; cop/con pulse for one cycle alongside the wrapped value.
module summation_m
  import summation_m_pkg::*;
#(
  parameter int M = SUM_M_DEF,
  parameter int W = SUM_W_DEF
) (
  input  logic                clk,
  input  logic                arst,
  input  logic signed [W-1:0] addend,
  output logic signed [W-1:0] cnt,
  output logic                cop,
  output logic                con
);

  logic signed [W-1:0] cnt_q = '0;
  logic                cop_q = 1'b0;
  logic                con_q = 1'b0;

  logic signed [W-1:0] cnt_d;
  logic                cop_d;
  logic                con_d;
  logic signed [W:0]   sum;

  logic signed [W-1:0] wrap_val;
  logic                wrap_carry;
  logic                wrap_borrow;

  // One extra bit keeps cnt + addend from overflowing.
  always_comb begin
    sum = {cnt_q[W-1], cnt_q} + {addend[W-1], addend};
  end

  mod_wrap #(
    .W(W),
    .M(M)
  ) u_mod_wrap (
    .s       (sum),
    .wrapped (wrap_val),
    .carry   (wrap_carry),
    .borrow  (wrap_borrow)
  );

  always_comb begin
    cnt_d = wrap_val;
    cop_d = wrap_carry;
    con_d = wrap_borrow;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_q <= '0;
      cop_q <= 1'b0;
      con_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cop_q <= cop_d;
      con_q <= con_d;
    end
  end

  assign cnt = cnt_q;
  assign cop = cop_q;
  assign con = con_q;

endmodule

// File: tb/tb_summation_m.sv
// Bench for summation_m: reference model pushes expectations into a queue,
// popped and compared after each clock edge.
module tb_summation_m;

  localparam int W = 11;
  localparam int M = 1000;

  logic                clk;
  logic                arst;
  logic signed [W-1:0] addend;
  logic signed [W-1:0] cnt;
  logic                cop;
  logic                con;

  int n_vec;
  int n_miss;
  int m_cnt;

  // {cop, con, cnt}
  logic [W+1:0] exp_q[$];

  summation_m #(
    .M(M),
    .W(W)
  ) dut (
    .clk    (clk),
    .arst   (arst),
    .addend (addend),
    .cnt    (cnt),
    .cop    (cop),
    .con    (con)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle; called #1 after a rising edge, returns #1 after the next.
  task automatic step(input int a, input logic rst);
    int           s;
    logic         e_cop;
    logic         e_con;
    logic [W+1:0] e;
    addend = 11'(a);
    arst   = rst;
    e_cop  = 1'b0;
    e_con  = 1'b0;
    if (rst) begin
      m_cnt = 0;
    end else begin
      s = m_cnt + a;
      if (s >= M) begin
        s     = s - M;
        e_cop = 1'b1;
      end else if (s < 0) begin
        s     = s + M;
        e_con = 1'b1;
      end
      m_cnt = s;
    end
    exp_q.push_back({e_cop, e_con, 11'(m_cnt)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cnt", {21'd0, cnt}, {21'd0, e[W-1:0]});
    check("cop", {31'd0, cop}, {31'd0, e[W+1]});
    check("con", {31'd0, con}, {31'd0, e[W]});
  endtask

  // Move the accumulator to target in one legal, non-wrapping step.
  task automatic go_to(input int target);
    step(target - m_cnt, 1'b0);
  endtask

  initial begin
    int a;
    n_vec  = 0;
    n_miss = 0;
    m_cnt  = 0;
    arst   = 1'b0;
    addend = '0;
    #1;
    check("init_cnt", {21'd0, cnt}, 32'd0);
    check("init_cop", {31'd0, cop}, 32'd0);
    check("init_con", {31'd0, con}, 32'd0);

    // reset held two edges with a nonzero addend, then release
    step(5, 1'b1);
    step(5, 1'b1);
    check("rst_cnt", {21'd0, cnt}, 32'd0);
    step(5, 1'b0);
    check("post_rst_cnt", {21'd0, cnt}, 32'd5);

    // ramp: 0..9, then -9..9 repeating
    step(0, 1'b1);
    for (int i = 0; i <= 9; i++) step(i, 1'b0);
    for (int r = 0; r < 12; r++) begin
      for (int v = -9; v <= 9; v++) begin
        step(v, 1'b0);
        check("ramp_range", {31'd0, ($signed(cnt) >= 0 && $signed(cnt) < M)}, 32'd1);
      end
    end

    // positive wrap
    go_to(995);
    step(9, 1'b0);
    check("pos_wrap_cnt", {21'd0, cnt}, 32'd4);
    check("pos_wrap_cop", {31'd0, cop}, 32'd1);
    step(0, 1'b0);
    check("pos_hold_cop", {31'd0, cop}, 32'd0);
    check("pos_hold_cnt", {21'd0, cnt}, 32'd4);

    // negative wrap
    go_to(3);
    step(-9, 1'b0);
    check("neg_wrap_cnt", {21'd0, cnt}, 32'd994);
    check("neg_wrap_con", {31'd0, con}, 32'd1);

    // exact boundaries
    go_to(991);
    step(9, 1'b0);
    check("s_eq_m_cnt", {21'd0, cnt}, 32'd0);
    check("s_eq_m_cop", {31'd0, cop}, 32'd1);
    go_to(9);
    step(-9, 1'b0);
    check("s_eq_0_cnt", {21'd0, cnt}, 32'd0);
    check("s_eq_0_flags", {30'd0, cop, con}, 32'd0);
    step(-1, 1'b0);
    check("zero_m1_cnt", {21'd0, cnt}, 32'd999);
    check("zero_m1_con", {31'd0, con}, 32'd1);

    // extreme legal addends
    go_to(999);
    step(999, 1'b0);
    check("ext_pos_cnt", {21'd0, cnt}, 32'd998);
    check("ext_pos_cop", {31'd0, cop}, 32'd1);
    step(-999, 1'b0);
    check("ext_neg_cnt", {21'd0, cnt}, 32'd999);
    check("ext_neg_con", {31'd0, con}, 32'd1);

    // reset on the same edge as a wrap suppresses the carry
    go_to(995);
    step(9, 1'b1);
    check("mid_rst_cnt", {21'd0, cnt}, 32'd0);
    check("mid_rst_cop", {31'd0, cop}, 32'd0);
    step(3, 1'b0);
    check("mid_rst_after", {21'd0, cnt}, 32'd3);

    // random legal addends
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 2 * (M - 1))) - (M - 1);
      step(a, 1'b0);
    end
    // occasional large steps near the boundaries
    for (int i = 0; i < 50; i++) begin
      a = int'($urandom_range(0, 1)) ? int'($urandom_range(M - 10, M - 1))
                                     : -int'($urandom_range(M - 10, M - 1));
      step(a, 1'b0);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
